// File: rtl/despachador_llamadas_pkg.sv
// Shared floor/direction codes and the SCAN target-selection helper for the elevator dispatcher.
// The car controller also uses these codes.
package despachador_llamadas_pkg;

    typedef enum logic [1:0] {
        PISO_MENOS1 = 2'b00,
        PISO_1      = 2'b01,
        PISO_2      = 2'b10,
        PISO_3      = 2'b11
    } piso_t;

    typedef enum logic [1:0] {
        DIR_NADA   = 2'b00,
        DIR_ARRIBA = 2'b01,
        DIR_ABAJO  = 2'b10
    } direccion_t;

    typedef enum logic {
        SENTIDO_ARRIBA = 1'b0,
        SENTIDO_ABAJO  = 1'b1
    } sentido_t;

    typedef struct packed {
        logic [1:0] destino;
        sentido_t   sentido;
    } seleccion_t;

    localparam int unsigned NUM_PISOS = 4;

    // Floor codes are monotonic in height, so plain numeric compares give above/below.
    function automatic seleccion_t seleccionar(input logic [NUM_PISOS-1:0] disp,
                                               input logic [1:0] piso,
                                               input sentido_t sentido);
        seleccion_t sel;
        logic       hay_arriba;
        logic       hay_abajo;
        logic [1:0] menor_arriba;
        logic [1:0] mayor_abajo;
        hay_arriba   = 1'b0;
        hay_abajo    = 1'b0;
        menor_arriba = '0;
        mayor_abajo  = '0;
        for (int unsigned j = 0; j < NUM_PISOS; j++) begin
            if (disp[j] && (j > 32'(piso)) && !hay_arriba) begin
                menor_arriba = 2'(j);
                hay_arriba   = 1'b1;
            end
            if (disp[j] && (j < 32'(piso))) begin
                mayor_abajo = 2'(j);
                hay_abajo   = 1'b1;
            end
        end
        sel.destino = piso;
        sel.sentido = sentido;
        if (sentido == SENTIDO_ARRIBA) begin
            if (hay_arriba) begin
                sel.destino = menor_arriba;
            end else if (hay_abajo) begin
                sel.destino = mayor_abajo;
                sel.sentido = SENTIDO_ABAJO;
            end
        end else begin
            if (hay_abajo) begin
                sel.destino = mayor_abajo;
            end else if (hay_arriba) begin
                sel.destino = menor_arriba;
                sel.sentido = SENTIDO_ARRIBA;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/despachador_llamadas_sincronizador_botones.sv
// Multi-flop synchroniser for the asynchronous push-button levels.
module sincronizador_botones #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ANCHO       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    logic [ANCHO-1:0] etapas [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                etapas[i] <= '0;
            end
        end else begin
            etapas[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                etapas[i] <= etapas[i-1];
            end
        end
    end

    assign q = etapas[SYNC_STAGES-1];

endmodule

// File: rtl/despachador_llamadas.sv
// Elevator call dispatcher: latches cabin/hall requests and picks the next target with SCAN.
module despachador_llamadas
    import despachador_llamadas_pkg::*;
#(
    parameter logic [1:0]  PISO_INICIAL = 2'b01,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] boton_cabina,
    input  logic [3:0] boton_piso,
    input  logic [1:0] piso,
    input  logic [1:0] direccion,
    input  logic       puertas_abiertas,
    output logic [1:0] destino,
    output logic [3:0] pendientes,
    output logic       hay_pedido
);

    logic [3:0] req_s;
    logic [3:0] servir;
    logic [3:0] disponibles;
    logic [3:0] pendientes_sig;
    logic [1:0] destino_sig;
    logic       bloqueado;
    seleccion_t sel;
    sentido_t   sentido, sentido_sig;

    sincronizador_botones #(
        .SYNC_STAGES(SYNC_STAGES),
        .ANCHO      (4)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (boton_cabina | boton_piso),
        .q  (req_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            destino    <= PISO_INICIAL;
            pendientes <= '0;
            hay_pedido <= 1'b0;
            sentido    <= SENTIDO_ARRIBA;
        end else begin
            destino    <= destino_sig;
            pendientes <= pendientes_sig;
            hay_pedido <= |pendientes;
            sentido    <= sentido_sig;
        end
    end

    // A floor being served this cycle is neither latched nor eligible as a target.
    always_comb begin
        servir         = '0;
        disponibles    = '0;
        pendientes_sig = '0;
        destino_sig    = destino;
        sentido_sig    = sentido;
        bloqueado      = 1'b0;
        if (puertas_abiertas) begin
            servir = 4'b0001 << piso;
        end
        disponibles    = pendientes & ~servir;
        pendientes_sig = (pendientes | req_s) & ~servir;
        sel            = seleccionar(disponibles, piso, sentido);
        bloqueado      = ((direccion == DIR_ARRIBA) && (sel.destino < piso)) ||
                         ((direccion == DIR_ABAJO)  && (sel.destino > piso));
        if (!bloqueado) begin
            destino_sig = sel.destino;
            sentido_sig = sel.sentido;
        end
    end

endmodule
